// File: rtl/change_dispenser.sv
// Refund payout engine: pays a requested amount as quarter/dime/nickel pulses
// using greedy selection bounded by coin stock, then acknowledges with a four-phase handshake.
module change_dispenser #(
    parameter int CHANGE_W = 8,
    parameter int CNT_W    = 8,
    parameter int COIN_GAP = 2,
    parameter int INIT_Q   = 10,
    parameter int INIT_D   = 10,
    parameter int INIT_N   = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cancelled,
    input  logic [CHANGE_W-1:0] change,
    input  logic                refill_valid,
    input  logic [1:0]          refill_sel,
    input  logic [CNT_W-1:0]    refill_qty,
    output logic                cancelledDone,
    output logic                coin_q,
    output logic                coin_d,
    output logic                coin_n,
    output logic                busy,
    output logic                short_change,
    output logic [CNT_W-1:0]    stock_q,
    output logic [CNT_W-1:0]    stock_d,
    output logic [CNT_W-1:0]    stock_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_EMIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CHANGE_W-1:0]   rem_q, rem_d;
    logic [3:0]            gap_q, gap_d;
    logic [2:0]            pulse_q, pulse_d;   // [0]=nickel [1]=dime [2]=quarter
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  short_q, short_d;

    logic [2:0]            elig;
    logic [2:0]            take;
    logic [CHANGE_W-1:0]   val_part [3];
    logic [CHANGE_W-1:0]   take_val;
    logic [CNT_W-1:0]      stk [3];

    // Coin index matches the refill_sel encoding: 0 nickel, 1 dime, 2 quarter.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_coin
            localparam int VAL  = (gi == 2) ? 25 : ((gi == 1) ? 10 : 5);
            localparam int INIT = (gi == 2) ? INIT_Q : ((gi == 1) ? INIT_D : INIT_N);

            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic [CNT_W:0]   sum;
            logic             add_hit;

            assign add_hit      = refill_valid && (refill_sel == 2'(gi));
            assign elig[gi]     = (rem_q >= CHANGE_W'(VAL)) && (cnt_q != '0);
            assign val_part[gi] = take[gi] ? CHANGE_W'(VAL) : '0;

            // One extra bit catches overflow; decrement only happens when cnt_q > 0.
            always_comb begin
                sum   = {1'b0, cnt_q}
                      + (add_hit ? {1'b0, refill_qty} : '0)
                      - {{CNT_W{1'b0}}, take[gi]};
                cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q <= CNT_W'(INIT);
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign stk[gi] = cnt_q;
        end
    endgenerate

    // Greedy priority: largest eligible coin wins.
    assign take = (state_q == S_PICK)
                ? {elig[2], elig[1] & ~elig[2], elig[0] & ~elig[1] & ~elig[2]}
                : 3'b000;
    assign take_val = val_part[0] | val_part[1] | val_part[2];

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        pulse_d = 3'b000;
        done_d  = done_q;
        short_d = short_q;

        case (state_q)
            S_IDLE: begin
                if (cancelled) begin
                    rem_d   = change;
                    short_d = 1'b0;
                    state_d = S_PICK;
                end
            end
            S_PICK: begin
                if (take != 3'b000) begin
                    rem_d   = rem_q - take_val;
                    pulse_d = take;
                    state_d = S_EMIT;
                end else begin
                    if (rem_q != '0) begin
                        short_d = 1'b1;
                    end
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_EMIT: begin
                if (COIN_GAP == 0) begin
                    state_d = S_PICK;
                end else begin
                    gap_d   = 4'(COIN_GAP - 1);
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = S_PICK;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            S_DONE: begin
                if (!cancelled) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            gap_q   <= '0;
            pulse_q <= 3'b000;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            short_q <= short_d;
        end
    end

    assign coin_n        = pulse_q[0];
    assign coin_d        = pulse_q[1];
    assign coin_q        = pulse_q[2];
    assign cancelledDone = done_q;
    assign busy          = busy_q;
    assign short_change  = short_q;
    assign stock_n       = stk[0];
    assign stock_d       = stk[1];
    assign stock_q       = stk[2];

endmodule

// File: tb/tb_change_dispenser.sv
// Directed and randomized refund transactions checked cycle by cycle against
// an arithmetic greedy-payout model of coin counts, timing and stock.
module tb_change_dispenser;

    localparam int CW   = 8;
    localparam int NW   = 8;
    localparam int G    = 2;
    localparam int SMAX = (1 << NW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          cancelled;
    logic [CW-1:0] change;
    logic          refill_valid;
    logic [1:0]    refill_sel;
    logic [NW-1:0] refill_qty;
    logic          cancelledDone, coin_q, coin_d, coin_n, busy, short_change;
    logic [NW-1:0] stock_q, stock_d, stock_n;

    int vectors     = 0;
    int miscompares = 0;
    int mq = 10, md = 10, mn = 10;
    int txn_no = 0;

    change_dispenser #(
        .CHANGE_W(CW), .CNT_W(NW), .COIN_GAP(G),
        .INIT_Q(10), .INIT_D(10), .INIT_N(10)
    ) dut (
        .clk(clk), .reset(reset), .cancelled(cancelled), .change(change),
        .refill_valid(refill_valid), .refill_sel(refill_sel), .refill_qty(refill_qty),
        .cancelledDone(cancelledDone), .coin_q(coin_q), .coin_d(coin_d), .coin_n(coin_n),
        .busy(busy), .short_change(short_change),
        .stock_q(stock_q), .stock_d(stock_d), .stock_n(stock_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int sat(input int v);
        return (v > SMAX) ? SMAX : v;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_refill(input logic [1:0] sel, input int qty);
        case (sel)
            2'b00:   mn = sat(mn + qty);
            2'b01:   md = sat(md + qty);
            2'b10:   mq = sat(mq + qty);
            default: ;
        endcase
    endtask

    task automatic check_stock(input string tag);
        check(tag, {8'h0, stock_q, stock_d, stock_n}, {8'h0, 8'(mq), 8'(md), 8'(mn)});
    endtask

    task automatic do_refill(input logic [1:0] sel, input int qty);
        @(negedge clk);
        refill_valid = 1'b1;
        refill_sel   = sel;
        refill_qty   = NW'(qty);
        @(negedge clk);
        refill_valid = 1'b0;
        model_refill(sel, qty);
        check_stock("refill_stock");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mq = 10; md = 10; mn = 10;
    endtask

    // Runs one refund. pulse=1: cancelled high for a single sampled cycle;
    // otherwise the controller drops it ext cycles after seeing cancelledDone.
    // An optional refill is presented on the edge that pays the first coin.
    task automatic run_txn(input int amt, input bit pulse, input int ext,
                           input bit ref_en, input logic [1:0] rsel, input int rqty);
        int rem, nq, nd, nn, n, per, d_rel, r_rel, e_rel, k;
        bit sh;
        logic [2:0] ec;
        logic [5:0] exp_v, obs_v;

        rem = amt;
        nq  = imin(rem / 25, mq); rem -= 25 * nq;
        nd  = imin(rem / 10, md); rem -= 10 * nd;
        nn  = imin(rem / 5,  mn); rem -= 5 * nn;
        sh  = (rem != 0);
        n     = nq + nd + nn;
        per   = 2 + G;
        d_rel = 1 + n * per;
        r_rel = pulse ? 0 : d_rel + ext;
        e_rel = (r_rel > d_rel) ? r_rel : d_rel;

        @(negedge clk);
        cancelled = 1'b1;
        change    = CW'(amt);
        for (int j = 0; j <= e_rel + 1; j++) begin
            @(negedge clk);
            ec = 3'b000;
            if (j >= 1 && ((j - 1) % per) == 0 && ((j - 1) / per) < n) begin
                k  = (j - 1) / per;
                ec = (k < nq) ? 3'b100 : ((k < nq + nd) ? 3'b010 : 3'b001);
            end
            exp_v = {ec, (j >= d_rel && j <= e_rel), (j <= e_rel), (j >= d_rel) ? sh : 1'b0};
            obs_v = {coin_q, coin_d, coin_n, cancelledDone, busy, short_change};
            check($sformatf("txn%0d_cyc%0d", txn_no, j), {26'h0, obs_v}, {26'h0, exp_v});
            change = CW'($urandom);
            if (ref_en && j == 0) begin
                refill_valid = 1'b1;
                refill_sel   = rsel;
                refill_qty   = NW'(rqty);
            end
            if (j == 1) refill_valid = 1'b0;
            if (j == r_rel) cancelled = 1'b0;
        end
        mq -= nq; md -= nd; mn -= nn;
        if (ref_en) model_refill(rsel, rqty);
        check_stock($sformatf("txn%0d_stock", txn_no));
        $display("txn %0d: change=%0d pulse=%0d coins q/d/n=%0d/%0d/%0d short=%0d stock=%0d/%0d/%0d",
                 txn_no, amt, pulse, nq, nd, nn, sh, mq, md, mn);
        txn_no++;
    endtask

    initial begin
        reset        = 1'b1;
        cancelled    = 1'b0;
        change       = '0;
        refill_valid = 1'b0;
        refill_sel   = 2'b00;
        refill_qty   = '0;

        #3;
        check("reset_outputs", {26'h0, coin_q, coin_d, coin_n, cancelledDone, busy, short_change}, 32'h0);
        check("reset_stock", {8'h0, stock_q, stock_d, stock_n}, {8'h0, 8'd10, 8'd10, 8'd10});
        @(negedge clk);
        reset = 1'b0;

        // 40 cents held: quarter, dime, nickel
        run_txn(40, 1'b0, 2, 1'b0, 2'b00, 0);
        check("t1_stock999", {8'h0, stock_q, stock_d, stock_n}, {8'h0, 8'd9, 8'd9, 8'd9});
        check("t1_short", {31'h0, short_change}, 32'h0);
        run_txn(7, 1'b0, 0, 1'b0, 2'b00, 0);
        check("t7_short", {31'h0, short_change}, 32'h1);
        run_txn(0, 1'b0, 1, 1'b0, 2'b00, 0);
        check("t0_short", {31'h0, short_change}, 32'h0);
        run_txn(50, 1'b1, 0, 1'b0, 2'b00, 0);
        check("t50_busy", {31'h0, busy}, 32'h0);

        // Drain to q=0 d=2 n=0, then pay 30 with two dimes and come up short
        do_reset();
        run_txn(250, 1'b0, 0, 1'b0, 2'b00, 0);
        run_txn(100, 1'b0, 0, 1'b0, 2'b00, 0);
        run_txn(50,  1'b0, 0, 1'b0, 2'b00, 0);
        do_refill(2'b01, 2);
        run_txn(30, 1'b0, 1, 1'b0, 2'b00, 0);
        check("t30_stock", {8'h0, stock_q, stock_d, stock_n}, 32'h0);
        check("t30_short", {31'h0, short_change}, 32'h1);

        // Saturation and ignored select
        do_refill(2'b10, 255);
        do_refill(2'b10, 5);
        check("sat_q", {24'h0, stock_q}, 32'd255);
        do_refill(2'b11, 9);

        // Refill of dimes on the same edge a dime is paid out: net +2
        do_refill(2'b01, 4);
        run_txn(10, 1'b0, 0, 1'b1, 2'b01, 3);
        check("refill_net", {24'h0, stock_d}, 32'd6);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0)
                do_refill(2'($urandom_range(0, 3)), $urandom_range(0, 20));
            run_txn($urandom_range(0, 255), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), 1'b0, 2'b00, 0);
        end

        // Asynchronous reset between first and second quarter of 75
        do_reset();
        @(negedge clk);
        cancelled = 1'b1;
        change    = CW'(75);
        @(negedge clk);
        @(negedge clk);
        check("ar_first_coin", {29'h0, coin_q, coin_d, coin_n}, 32'h4);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("ar_outputs", {29'h0, cancelledDone, busy, coin_q}, 32'h0);
        check("ar_stock", {8'h0, stock_q, stock_d, stock_n}, {8'h0, 8'd10, 8'd10, 8'd10});
        cancelled = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            check($sformatf("ar_quiet%0d", j),
                  {27'h0, coin_q, coin_d, coin_n, cancelledDone, busy}, 32'h0);
        end
        $display("txn %0d: async reset during change=75, dispense abandoned", txn_no);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Responder for the vending controller's cancel/refund handshake.
- The controller raises `cancelled` and presents the refund amount on `change`. This block pays the refund out as one-cycle coin pulses (quarter, dime, nickel) using greedy selection limited by on-board coin stock. It then answers with `cancelledDone` under a four-phase handshake.
- It also tracks the coin inventory and supports refill.

Parameters:
- CHANGE_W, 8: width of `change` in cents.
- CNT_W, 8: width of each coin stock counter; counters saturate at 2^CNT_W-1.
- COIN_GAP, 2: idle cycles after each coin pulse, for hopper settle. Legal range 0..15.
- INIT_Q, 10: quarter stock after reset.
- INIT_D, 10: dime stock after reset.
- INIT_N, 10: nickel stock after reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cancelled  in  1  refund request; held high by the controller until it sees `cancelledDone`.
- change  in  CHANGE_W  refund amount in cents; sampled only when a request is accepted.
- refill_valid  in  1  one-cycle refill strobe.
- refill_sel  in  2  00 = nickel, 01 = dime, 10 = quarter, 11 = ignored.
- refill_qty  in  CNT_W  number of coins added on a refill.
- cancelledDone  out  1  refund-complete acknowledge.
- coin_q  out  1  one-cycle quarter eject pulse.
- coin_d  out  1  one-cycle dime eject pulse.
- coin_n  out  1  one-cycle nickel eject pulse.
- busy  out  1  high in every state except IDLE.
- short_change  out  1  sticky per transaction: refund could not be fully paid.
- stock_q  out  CNT_W  current quarter stock.
- stock_d  out  CNT_W  current dime stock.
- stock_n  out  CNT_W  current nickel stock.

Behaviour:
- Reset (asynchronous):
  - state = IDLE.
  - All 1-bit outputs = 0.
  - rem = 0.
  - Stocks = INIT_Q, INIT_D, INIT_N.
  - Reset mid-dispense abandons the refund; no further coin pulses.
- States: IDLE, PICK, EMIT, GAP, DONE. All outputs are registered.
- IDLE:
  - `cancelled` = 1 sampled → rem <= change, short_change <= 0, go to PICK.
- PICK (greedy, first match wins):
  - rem >= 25 and stock_q > 0 → quarter.
  - Else rem >= 10 and stock_d > 0 → dime.
  - Else rem >= 5 and stock_n > 0 → nickel.
  - On a match: assert the matching coin_* next cycle, rem -= value, stock -= 1, go to EMIT.
  - rem == 0 → go to DONE.
  - rem != 0 and no coin matches (includes rem < 5) → short_change <= 1, go to DONE.
- EMIT:
  - Exactly one coin_* is high for this single cycle.
  - COIN_GAP = 0 → go to PICK; otherwise go to GAP.
- GAP:
  - Wait COIN_GAP cycles, then go to PICK.
- Coin spacing: one coin per 2 + COIN_GAP cycles. The first coin pulse is high 2 cycles after the edge that samples `cancelled`.
- DONE:
  - cancelledDone = 1.
  - Stay in DONE while `cancelled` = 1.
  - Leave when `cancelled` = 0 is sampled: cancelledDone <= 0, go to IDLE.
  - If `cancelled` was already low on entry, cancelledDone is high for exactly one cycle.
- Deassertion of `cancelled` before DONE is ignored; the refund always completes.
- A new request is not accepted until IDLE is re-entered. Back-to-back requests therefore need `cancelled` low for at least 1 sampled cycle.
- `change` is ignored outside IDLE.
- short_change holds its value until the next accepted request or reset.
- Refill:
  - Accepted in any state.
  - stock += refill_qty, saturating at 2^CNT_W-1.
  - A refill and a dispense decrement of the same coin in the same cycle are both applied: stock + qty - 1, saturating.
  - The stock value used by PICK is the registered value before that cycle's refill.
- Stock never underflows: PICK only selects a coin whose stock is > 0.

Test Plan:
- Default stock, COIN_GAP=2, change=40, `cancelled` held high → pulses coin_q, coin_d, coin_n, 4 cycles apart. cancelledDone rises after the nickel and falls the cycle after `cancelled` drops. Final stocks 9/9/9; short_change = 0.
- Stock q=0, d=2, n=0, change=30 → exactly two coin_d pulses. short_change = 1, cancelledDone = 1, stock_d = 0.
- change=7, default stock → one coin_n; then short_change = 1 and cancelledDone asserted. change=0 → no coin pulses; cancelledDone high 2 cycles after the request is sampled; short_change = 0.
- `cancelled` pulsed high for 1 cycle, change=50 → two coin_q pulses still issued. cancelledDone high exactly 1 cycle. busy = 0 afterwards.
- stock_q=255, then refill_valid with sel=10, qty=5 → stock_q stays 255. Refill of dimes, qty=3, in the same cycle a dime is dispensed → stock_d increases by net +2.
- reset asserted asynchronously between the 1st and 2nd coin of change=75 → no further pulses. busy = 0 and cancelledDone = 0 immediately. Stocks return to 10/10/10.
